// File: rtl/char_glyph_fetch.sv
// char_glyph_fetch
// Text-mode glyph fetch sequencer. For each character cell of the active line
// it reads the character code from the text RAM, strobes the character ROM at
// {char_code, glyph_row[2:0]}, and serialises the glyph row MSB first, padded
// with gap pixels and XORed with a blinking cursor. Pixel output lags
// line_start by a fixed 3 pix_en ticks.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   pix_en               pixel clock enable; nothing advances while it is 0
//   frame_start          start-of-frame pulse (aborts any line, resets rows)
//   line_start           start-of-active-line pulse (restarts at column 0)
//   cursor_en/col/row    cursor enable and character position
//   text_col/row/ce      text RAM read port (1-cycle latency) -> char_code
//   rom_ad/rom_ce        character ROM read port (1-cycle latency) -> rom_dout
//   pixel_out            serial pixel, 1 = foreground
//   pixel_valid          pixel_out is an active pixel
//   busy                 a line is in progress
module char_glyph_fetch #(
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int CELL_W       = 6,
    parameter int ROW_H        = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [6:0]  text_col,
    output logic [4:0]  text_row,
    output logic        text_ce,
    input  logic [7:0]  char_code,
    output logic [10:0] rom_ad,
    output logic        rom_ce,
    input  logic [4:0]  rom_dout,
    output logic        pixel_out,
    output logic        pixel_valid,
    output logic        busy
);

    localparam int N_PIX = COLS * CELL_W;
    localparam int TW    = $clog2(N_PIX + 4);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [3:0]        ph;          // pixel position within the fetch cell
    logic [TW-1:0]     tcnt;        // pix_en ticks since line_start
    logic [TW-1:0]     tcnt_nxt;
    // [0] RAM fetch strobe, [1] ROM strobe, [2] shifter load next tick
    logic [2:0]        vld_pipe;
    logic [2:1]        cur_pipe;    // cursor hit travelling alongside vld_pipe
    logic [CELL_W-1:0] shreg;
    logic              inv;
    logic [3:0]        glyph_row;
    logic [4:0]        char_row;
    logic [7:0]        blink_cnt;
    logic              blink_phase;
    logic              blank;
    logic              cursor_hit;
    logic [CELL_W-1:0] glyph_bits;

    assign tcnt_nxt   = tcnt + TW'(1);
    assign blank      = (glyph_row >= 4'd8);
    assign cursor_hit = cursor_en & blink_phase & (text_col == cursor_col) &
                        (char_row == cursor_row);
    // Left-align the 5 glyph bits in the cell; narrow cells keep only the MSBs.
    assign glyph_bits = blank ? '0 : CELL_W'({rom_dout, 11'b0} >> (16 - CELL_W));

    assign text_row    = char_row;
    assign text_ce     = vld_pipe[0] & pix_en;
    assign rom_ce      = vld_pipe[1] & ~blank & pix_en;
    assign rom_ad      = {char_code, glyph_row[2:0]};
    assign busy        = (state != IDLE);
    assign pixel_out   = pixel_valid & (shreg[CELL_W-1] ^ inv);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ph          <= '0;
            tcnt        <= '0;
            vld_pipe    <= '0;
            cur_pipe    <= '0;
            shreg       <= '0;
            inv         <= 1'b0;
            text_col    <= '0;
            pixel_valid <= 1'b0;
            glyph_row   <= '0;
            char_row    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (pix_en) begin
            if (frame_start) begin
                if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end

            // Datapath free-runs; later assignments below override on restart/abort.
            vld_pipe[2:1] <= vld_pipe[1:0];
            cur_pipe      <= {cur_pipe[1], cursor_hit};
            if (vld_pipe[2]) begin
                shreg <= glyph_bits;
                inv   <= cur_pipe[2];
            end else begin
                shreg <= shreg << 1;
            end

            if (frame_start) begin
                glyph_row   <= '0;
                char_row    <= '0;
                state       <= IDLE;
                pixel_valid <= 1'b0;
                vld_pipe    <= '0;
            end

            if (line_start) begin
                state       <= RUN;
                text_col    <= '0;
                ph          <= '0;
                tcnt        <= '0;
                vld_pipe    <= 3'b001;
                pixel_valid <= 1'b0;
            end else if (!frame_start && state != IDLE) begin
                tcnt <= tcnt_nxt;
                if (tcnt_nxt == TW'(3))
                    pixel_valid <= 1'b1;
                if (tcnt_nxt == TW'(N_PIX + 3)) begin
                    // Final pixel tick: line complete, advance the row.
                    pixel_valid <= 1'b0;
                    state       <= IDLE;
                    if (glyph_row == 4'(ROW_H - 1)) begin
                        glyph_row <= '0;
                        char_row  <= (char_row == 5'(ROWS - 1)) ? 5'd0 : char_row + 5'd1;
                    end else begin
                        glyph_row <= glyph_row + 4'd1;
                    end
                end else if (state == RUN) begin
                    if (vld_pipe[0] && text_col == 7'(COLS - 1))
                        state <= DRAIN;
                    if (ph == 4'(CELL_W - 1)) begin
                        ph          <= '0;
                        text_col    <= text_col + 7'd1;
                        vld_pipe[0] <= 1'b1;
                    end else begin
                        ph          <= ph + 4'd1;
                        vld_pipe[0] <= 1'b0;
                    end
                end else begin
                    vld_pipe[0] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_glyph_fetch.sv
// Testbench for char_glyph_fetch: text RAM / character ROM models, a
// line-level behavioural reference (expected pixel list per line, tick index
// since line_start) compared every cycle, plus directed literal checks.
module tb_char_glyph_fetch;

    localparam int COLS   = 3;
    localparam int ROWS   = 3;
    localparam int CELL_W = 6;
    localparam int ROW_H  = 10;
    localparam int BF     = 2;
    localparam int NPIX   = COLS * CELL_W;

    logic        clk = 1'b0;
    logic        reset, pix_en, frame_start, line_start, cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [6:0]  text_col;
    logic [4:0]  text_row;
    logic        text_ce;
    logic [7:0]  char_code = 8'h00;
    logic [10:0] rom_ad;
    logic        rom_ce;
    logic [4:0]  rom_dout = 5'h00;
    logic        pixel_out, pixel_valid, busy;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    always #5 clk = ~clk;

    char_glyph_fetch #(
        .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .ROW_H(ROW_H), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .frame_start(frame_start),
        .line_start(line_start), .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .text_col(text_col), .text_row(text_row),
        .text_ce(text_ce), .char_code(char_code), .rom_ad(rom_ad), .rom_ce(rom_ce),
        .rom_dout(rom_dout), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .busy(busy)
    );

    logic [7:0] ram [ROWS][COLS];

    function automatic logic [4:0] glyph(input logic [7:0] code, input logic [2:0] row);
        int v;
        if (code == 8'h41) begin
            case (row)
                3'd0: return 5'b00100;
                3'd1: return 5'b01010;
                3'd2: return 5'b10001;
                3'd3: return 5'b10001;
                3'd4: return 5'b11111;
                3'd5: return 5'b10001;
                3'd6: return 5'b10001;
                default: return 5'b00000;
            endcase
        end
        v = (int'(code) * 7 + int'(row) * 13) ^ (int'(code) >> 2);
        return 5'(v);
    endfunction

    // Text RAM and character ROM: synchronous read on enable, hold otherwise.
    always @(posedge clk) begin
        if (text_ce)
            char_code <= (text_row < ROWS && text_col < COLS) ? ram[text_row][text_col] : 8'hEE;
        if (rom_ce)
            rom_dout <= glyph(rom_ad[10:3], rom_ad[2:0]);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int g = 0, cr = 0, bcnt = 0, j = 0;
    bit bph = 0, act = 0;
    bit exp_px[$];
    bit m_inv;
    logic [4:0] m_gl;

    always @(posedge clk) begin
        if (reset) begin
            g = 0; cr = 0; bcnt = 0; bph = 0; act = 0; j = 0;
        end else if (pix_en) begin
            if (frame_start) begin
                bcnt++;
                if (bcnt == BF) begin bcnt = 0; bph = !bph; end
                g = 0; cr = 0; act = 0;
            end else if (!line_start && act) begin
                j++;
                if (j == NPIX + 3) begin
                    act = 0;
                    if (g == ROW_H - 1) begin g = 0; cr = (cr + 1) % ROWS; end
                    else g++;
                end
            end
            if (line_start) begin
                act = 1; j = 0;
                exp_px.delete();
                for (int c = 0; c < COLS; c++) begin
                    m_inv = cursor_en && bph && (c == int'(cursor_col)) && (cr == int'(cursor_row));
                    m_gl  = (g < 8) ? glyph(ram[cr][c], 3'(g)) : 5'b0;
                    for (int p = 0; p < CELL_W; p++)
                        exp_px.push_back(((p < 5) ? m_gl[4-p] : 1'b0) ^ m_inv);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev, tce, rce;
        if (chk_on) begin
            ev  = act && j >= 3 && j <= NPIX + 2;
            tce = act && (j % CELL_W == 0) && j < NPIX && pix_en;
            rce = act && j >= 1 && ((j - 1) % CELL_W == 0) && (j - 1) < NPIX && g < 8 && pix_en;
            chk("busy", busy, act);
            chk("pixel_valid", pixel_valid, ev);
            chk("pixel_out", pixel_out, ev ? exp_px[j-3] : 1'b0);
            chk("text_row", text_row, cr);
            chk("text_ce", text_ce, tce);
            if (tce) chk("text_col", text_col, j / CELL_W);
            chk("rom_ce", rom_ce, rce);
            if (rce) chk("rom_ad", rom_ad, {ram[cr][(j-1)/CELL_W], 3'(g)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit pe, input bit fs, input bit ls);
        @(posedge clk); #2;
        pix_en = pe; frame_start = fs; line_start = ls;
    endtask

    task automatic run_line();
        tick(1, 0, 1);
        repeat (NPIX + 4) tick(1, 0, 0);
    endtask

    task automatic run_line_lit(input string tag, input bit do_ad, input logic [10:0] ead,
                                input logic [5:0] c0, input logic [5:0] c1);
        int nv;
        logic [5:0] g0, g1;
        nv = 0; g0 = '0; g1 = '0;
        tick(1, 0, 1);
        for (int k = 0; k <= NPIX + 4; k++) begin
            tick(1, 0, 0);
            @(negedge clk);
            if (k == 1 && do_ad) chk({tag, " rom_ad"}, rom_ad, ead);
            if (k >= 3 && k <= 8)  g0[8-k]  = pixel_out;
            if (k >= 9 && k <= 14) g1[14-k] = pixel_out;
            if (pixel_valid) nv++;
        end
        chk({tag, " cell0"}, g0, c0);
        chk({tag, " cell1"}, g1, c1);
        chk({tag, " valid_len"}, nv, NPIX);
    endtask

    initial begin
        bit pe, fs, ls, dense;
        reset = 1; pix_en = 0; frame_start = 0; line_start = 0;
        cursor_en = 1; cursor_col = 7'd1; cursor_row = 5'd0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ram[r][c] = (r == 0) ? 8'h41 : 8'($urandom_range(0, 255));
        @(posedge clk); @(posedge clk); #2;
        reset = 0; chk_on = 1;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset pixel_valid", pixel_valid, 0);
        chk("reset text_ce", text_ce, 0);
        chk("reset text_row", text_row, 0);

        // Frame 1: blink phase off.
        tick(1, 1, 0);
        run_line_lit("line g0", 1, 11'h208, 6'b001000, 6'b001000);
        repeat (3) run_line();
        run_line_lit("line g4", 1, 11'h20C, 6'b111110, 6'b111110);
        repeat (3) run_line();
        run_line_lit("blank g8", 0, 11'h0, 6'b000000, 6'b000000);
        run_line();

        // Frame 2: blink phase on, cursor on cell 1 of row 0.
        tick(1, 1, 0);
        run_line_lit("cursor", 1, 11'h208, 6'b001000, 6'b110111);

        // line_start sampled at E_5 restarts at column 0, glyph row stays 1.
        tick(1, 0, 1);
        repeat (4) tick(1, 0, 0);
        tick(1, 0, 1);
        tick(1, 0, 0);
        tick(1, 0, 0);
        @(negedge clk);
        chk("restart rom_ce", rom_ce, 1);
        chk("restart glyph_row", rom_ad[2:0], 1);
        repeat (NPIX + 2) tick(1, 0, 0);

        // Reset sampled at E_4.
        tick(1, 0, 1);
        repeat (4) tick(1, 0, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("midreset busy", busy, 0);
        chk("midreset pixel_valid", pixel_valid, 0);
        chk("midreset pixel_out", pixel_out, 0);
        chk("midreset text_ce", text_ce, 0);
        chk("midreset rom_ce", rom_ce, 0);
        chk("midreset text_col", text_col, 0);

        // Advance to char row 1, then frame_start + line_start together.
        repeat (ROW_H + 1) run_line();
        chk("pre-coincident text_row", text_row, 1);
        tick(1, 1, 1);
        tick(1, 0, 0);
        tick(1, 0, 0);
        @(negedge clk);
        chk("coincident text_row", text_row, 0);
        chk("coincident glyph_row", rom_ad[2:0], 0);
        repeat (NPIX + 2) tick(1, 0, 0);

        // char_row wrap ROWS-1 -> 0.
        repeat (19) run_line();
        tick(1, 0, 0);
        @(negedge clk);
        chk("wrap pre text_row", text_row, 2);
        repeat (10) run_line();
        tick(1, 0, 0);
        @(negedge clk);
        chk("wrap text_row", text_row, 0);

        // Randomised phase, checked by the model every cycle.
        dense = 1;
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) dense = ($urandom_range(0, 1) == 1);
            pe = dense ? 1'b1 : ($urandom_range(0, 1) == 1);
            fs = ($urandom_range(0, 599) == 0);
            ls = busy ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 5) == 0);
            if (fs || ls) pe = 1'b1;
            tick(pe, fs, ls);
            if (fs) begin
                cursor_en  = ($urandom_range(0, 3) != 0);
                cursor_col = 7'($urandom_range(0, COLS - 1));
                cursor_row = 5'($urandom_range(0, ROWS - 1));
            end
            reset = ($urandom_range(0, 1999) == 0);
        end
        tick(0, 0, 0);
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
